// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured word out MSB-first, repeated reps+1 times.
// Optional even-parity bit after each word when SEQ_PATTERN_TX_PARITY_EN is defined.
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] reps,
    input  logic             abort,
    output logic             outp,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int BC_W = $clog2(WIDTH);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             outp_q, outp_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             word_end;

`ifdef SEQ_PATTERN_TX_PARITY_EN
    logic par_q, par_d;

    // The repeat/DONE decision waits for the parity cycle that follows the last data bit.
    assign word_end = par_q;
`else
    assign word_end = (bit_cnt_q == BIT_LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            outp_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            outp_q      <= outp_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (load) state_d = SEND;
                SEND:    if (word_end && rep_cnt_q == '0) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered, so the bit on outp is computed one cycle ahead: shreg holds
    // only the bits not yet presented, and bit_cnt indexes the bit currently on outp.
    always_comb begin
        data_d      = data_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        outp_d      = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
        par_d       = 1'b0;
`endif
        if (abort) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
            rep_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        data_d      = data;
                        shreg_d     = data << 1;
                        rep_cnt_d   = reps;
                        bit_cnt_d   = '0;
                        outp_d      = data[WIDTH-1];
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
                SEND: begin
                    busy_d = 1'b1;
                    if (word_end) begin
                        if (rep_cnt_q != '0) begin
                            rep_cnt_d   = rep_cnt_q - 1'b1;
                            shreg_d     = data_q << 1;
                            bit_cnt_d   = '0;
                            outp_d      = data_q[WIDTH-1];
                            out_valid_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    else if (bit_cnt_q == BIT_LAST) begin
                        par_d       = 1'b1;
                        outp_d      = ^data_q;
                        out_valid_d = 1'b1;
                    end
`endif
                    else begin
                        outp_d      = shreg_q[WIDTH-1];
                        shreg_d     = shreg_q << 1;
                        bit_cnt_d   = bit_cnt_q + 1'b1;
                        out_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign outp      = outp_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: table of transfers checked cycle by cycle against a bit-queue
// scoreboard, plus hand sequences for reset and load/abort corner cases.
module tb_seq_pattern_tx;

    localparam int W  = 8;
    localparam int CW = 4;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int WL = W + 1;
`else
    localparam int WL = W;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  data = '0;
    logic [CW-1:0] reps = '0;
    logic          outp, out_valid, busy, done;

    int n_vec = 0;
    int n_err = 0;
    bit exp_q[$];

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] reps;
        int            abort_cyc;
        string         name;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data      (data),
        .reps      (reps),
        .abort     (abort),
        .outp      (outp),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [3:0] obs();
        return {outp, out_valid, busy, done};
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b ({outp,out_valid,busy,done})", name, act, exp);
        end
    endtask

    // One transfer: cycle c is the c-th cycle after the edge that samples load.
    task automatic run_vec(input vec_t v);
        int n_bits, n_valid, last;
        logic [3:0] e;
        bit b;
        n_bits = (int'(v.reps) + 1) * WL;
        exp_q.delete();
        for (int r = 0; r <= int'(v.reps); r++) begin
            for (int i = W - 1; i >= 0; i--) exp_q.push_back(v.data[i]);
`ifdef SEQ_PATTERN_TX_PARITY_EN
            exp_q.push_back(^v.data);
`endif
        end
        n_valid = (v.abort_cyc != 0) ? v.abort_cyc : n_bits;
        while (exp_q.size() > n_valid) void'(exp_q.pop_back());
        last = (v.abort_cyc != 0) ? v.abort_cyc + 2 : n_bits + 2;

        @(negedge clk);
        data = v.data;
        reps = v.reps;
        load = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c <= n_valid) begin
                b = exp_q.pop_front();
                e = {b, 3'b110};
            end else if (v.abort_cyc == 0 && c == n_bits + 1) begin
                e = 4'b0011;
            end else begin
                e = 4'b0000;
            end
            chk($sformatf("%s_c%0d", v.name, c), obs(), e);
            if (c == 1) begin
                load = 1'b0;
                data = ~v.data;
                reps = CW'($urandom);
            end
            if (c == 3) load = 1'b1;
            if (c == 4) load = 1'b0;
            if (v.abort_cyc == 0 && c == n_bits + 1) load = 1'b1;
            if (v.abort_cyc == 0 && c == n_bits + 2) load = 1'b0;
            if (c == v.abort_cyc) abort = 1'b1;
            if (c == v.abort_cyc + 1) abort = 1'b0;
        end
        load  = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hB4, 4'd0,  0,  "b4_r0"};
        vecs[1] = '{8'h81, 4'd2,  0,  "81_r2"};
        vecs[2] = '{8'hFF, 4'd3,  4,  "ff_abort4"};
        vecs[3] = '{8'hB5, 4'd0,  0,  "b5_r0"};
        vecs[4] = '{8'h3C, 4'd15, 0,  "3c_rmax"};
        vecs[5] = '{8'hA5, 4'd1,  10, "a5_abort10"};

        @(negedge clk);
        chk("reset_state", obs(), 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", obs(), 4'b0000);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // load and abort together in IDLE: abort wins, nothing starts
        @(negedge clk);
        load  = 1'b1;
        abort = 1'b1;
        data  = 8'hFF;
        reps  = 4'd3;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("load_abort_idle_c%0d", c), obs(), 4'b0000);
            load  = 1'b0;
            abort = 1'b0;
        end

        // asynchronous reset in the middle of a word, observed before any clock edge
        @(negedge clk);
        load = 1'b1;
        data = 8'hFF;
        reps = 4'd3;
        @(negedge clk);
        load = 1'b0;
        chk("pre_reset_send", obs(), 4'b1110);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_midword", obs(), 4'b0000);
        @(negedge clk);
        chk("reset_held", obs(), 4'b0000);
        rst_n = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk($sformatf("idle_after_midword_reset_c%0d", c), obs(), 4'b0000);
        end

        // asynchronous reset while idle
        #2 rst_n = 1'b0;
        #1 chk("async_reset_idle", obs(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
